mandel_scheduler: RTL and testbench

Frame-render scheduler for the Mandelbrot datapath. It walks every pixel of the H_RES x V_RES frame and dispatches each pixel as a job to the first free engine out of NUM_ENG iteration engines. Engines may finish out of order; a round-robin arbiter collects their results and drives the single BRAM write port (port A, CLK domain). The pixel-clock read side is outside this block.

---
 rtl/mandel_scheduler_if.sv | 42 ++++
 rtl/mandel_scheduler.sv | 293 +++++++++++++++++++++++++++++
 tb/tb_mandel_scheduler.sv | 283 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mandel_scheduler_if.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : mandel_scheduler_if
// Description : Bundle of the scheduler's control, engine-dispatch, engine-
//               result and BRAM-write signals.
//               slave  - the scheduler itself (drives status, dispatch, write)
//               master - the environment (drives start and engine results)
// Ports       : start, busy, frame_done          frame control
//               job_x, job_y, eng_start          job dispatch to the engines
//               eng_done, eng_iter               engine results
//               wr_en, wr_addr, wr_data          BRAM port A write
// Revision    : 1.0 - initial release
// ============================================================================
interface mandel_scheduler_if #(
    parameter int NUM_ENG    = 4,
    parameter int ADDR_WIDTH = 19,
    parameter int ITER_WIDTH = 5
);
    logic                          start;
    logic                          busy;
    logic                          frame_done;
    logic [15:0]                   job_x;
    logic [15:0]                   job_y;
    logic [NUM_ENG-1:0]            eng_start;
    logic [NUM_ENG-1:0]            eng_done;
    logic [NUM_ENG*ITER_WIDTH-1:0] eng_iter;
    logic                          wr_en;
    logic [ADDR_WIDTH-1:0]         wr_addr;
    logic [ITER_WIDTH-1:0]         wr_data;

    modport slave (
        input  start, eng_done, eng_iter,
        output busy, frame_done, job_x, job_y, eng_start, wr_en, wr_addr, wr_data
    );

    modport master (
        output start, eng_done, eng_iter,
        input  busy, frame_done, job_x, job_y, eng_start, wr_en, wr_addr, wr_data
    );
endinterface
`default_nettype wire

// File: rtl/mandel_scheduler.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : mandel_scheduler
// Description : Frame-render scheduler. Walks the H_RES x V_RES frame in
//               raster order, hands each pixel to the lowest-index free
//               iteration engine, collects out-of-order results through a
//               round-robin arbiter and writes them to BRAM port A.
// Ports       : CLK    - system clock
//               RESET  - asynchronous active-low reset (engines share it)
//               bus    - mandel_scheduler_if.slave (control, dispatch,
//                        engine results, BRAM write)
// Revision    : 1.0 - initial release
// ============================================================================
module mandel_scheduler #(
    parameter int H_RES      = 800,
    parameter int V_RES      = 600,
    parameter int NUM_ENG    = 4,
    parameter int ADDR_WIDTH = 19,
    parameter int ITER_WIDTH = 5
) (
    input  wire logic          CLK,
    input  wire logic          RESET,
    mandel_scheduler_if.slave  bus
);
    localparam int                    c_TOTAL    = H_RES * V_RES;
    localparam int                    c_PTR_W    = (NUM_ENG > 1) ? $clog2(NUM_ENG) : 1;
    localparam logic [ADDR_WIDTH-1:0] c_LAST_PIX = ADDR_WIDTH'(c_TOTAL - 1);
    localparam logic [15:0]           c_LAST_X   = 16'(H_RES - 1);

    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_DISPATCH = 2'd1,
        S_DRAIN    = 2'd2,
        S_DONE     = 2'd3
    } state_t;

    state_t r_state;
    state_t w_state_nxt;

    // Registered outputs
    logic                  r_busy;
    logic                  r_frame_done;
    logic [15:0]           r_job_x;
    logic [15:0]           r_job_y;
    logic [NUM_ENG-1:0]    r_eng_start;
    logic                  r_wr_en;
    logic [ADDR_WIDTH-1:0] r_wr_addr;
    logic [ITER_WIDTH-1:0] r_wr_data;

    // Engine table and result buffers
    logic [NUM_ENG-1:0]    r_eng_busy;
    logic [NUM_ENG-1:0]    r_pend;
    logic [ADDR_WIDTH-1:0] r_tag [NUM_ENG];
    logic [ITER_WIDTH-1:0] r_res [NUM_ENG];
    logic [c_PTR_W-1:0]    r_rr_ptr;

    // Raster walk
    logic [ADDR_WIDTH-1:0] r_pix;
    logic [15:0]           r_x;
    logic [15:0]           r_y;
    logic                  r_restart;

    // Combinational
    logic [NUM_ENG-1:0]    w_disp_oh;
    logic                  w_any_free;
    logic                  w_do_dispatch;
    logic [NUM_ENG-1:0]    w_done_ok;
    logic [NUM_ENG-1:0]    w_done_acc;
    logic                  w_grant_vld;
    logic [c_PTR_W-1:0]    w_grant_idx;
    logic [NUM_ENG-1:0]    w_grant_oh;
    logic [c_PTR_W-1:0]    w_rr_nxt;
    logic                  w_hi_found;
    logic [c_PTR_W-1:0]    w_hi_idx;
    logic                  w_lo_found;
    logic [c_PTR_W-1:0]    w_lo_idx;
    logic                  w_all_idle;
    logic                  w_clr_cnt;
    logic                  w_set_restart;
    logic                  w_clr_restart;

    // ------------------------------------------------------------------------
    // Dispatch target: lowest-index engine free at the start of the cycle.
    // Scanning downward lets the lowest free index overwrite the others.
    // ------------------------------------------------------------------------
    always_comb begin
        w_disp_oh  = '0;
        w_any_free = 1'b0;
        for (int i = NUM_ENG - 1; i >= 0; i--) begin
            if (!r_eng_busy[i]) begin
                w_disp_oh    = '0;
                w_disp_oh[i] = 1'b1;
                w_any_free   = 1'b1;
            end
        end
    end

    // A start in DISPATCH turns into a restart request, so no job goes out in
    // that cycle; the frame drains and begins again from pixel 0.
    assign w_do_dispatch = (r_state == S_DISPATCH) && !bus.start && w_any_free;

    // Only a busy engine with no result waiting may report a result.
    assign w_done_ok  = r_eng_busy & ~r_pend;
    assign w_done_acc = bus.eng_done & w_done_ok;

    // ------------------------------------------------------------------------
    // Round-robin arbiter over pend: the first pending engine at or above the
    // pointer wins; otherwise the search wraps to the lowest pending engine.
    // ------------------------------------------------------------------------
    always_comb begin
        w_hi_found = 1'b0;
        w_hi_idx   = '0;
        w_lo_found = 1'b0;
        w_lo_idx   = '0;
        for (int i = NUM_ENG - 1; i >= 0; i--) begin
            if (r_pend[i]) begin
                w_lo_found = 1'b1;
                w_lo_idx   = c_PTR_W'(i);
                if (i >= int'(r_rr_ptr)) begin
                    w_hi_found = 1'b1;
                    w_hi_idx   = c_PTR_W'(i);
                end
            end
        end
        w_grant_vld = w_lo_found;
        w_grant_idx = w_hi_found ? w_hi_idx : w_lo_idx;
        w_grant_oh  = '0;
        for (int i = 0; i < NUM_ENG; i++) begin
            w_grant_oh[i] = w_grant_vld && (w_grant_idx == c_PTR_W'(i));
        end
        w_rr_nxt = (int'(w_grant_idx) == NUM_ENG - 1) ? '0 : w_grant_idx + c_PTR_W'(1);
    end

    assign w_all_idle = (r_eng_busy == '0) && (r_pend == '0);

    // ------------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------------
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ------------------------------------------------------------------------
    // FSM: next state and control strobes
    // ------------------------------------------------------------------------
    always_comb begin
        w_state_nxt   = r_state;
        w_clr_cnt     = 1'b0;
        w_set_restart = 1'b0;
        w_clr_restart = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (bus.start) begin
                    w_state_nxt = S_DISPATCH;
                    w_clr_cnt   = 1'b1;
                end
            end
            S_DISPATCH: begin
                if (bus.start) begin
                    w_set_restart = 1'b1;
                    w_state_nxt   = S_DRAIN;
                end else if (w_do_dispatch && (r_pix == c_LAST_PIX)) begin
                    w_state_nxt = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (bus.start) begin
                    w_set_restart = 1'b1;
                end
                if (w_all_idle) begin
                    // A start arriving in the very cycle the drain completes
                    // still counts as a restart.
                    if (r_restart || bus.start) begin
                        w_clr_restart = 1'b1;
                        w_clr_cnt     = 1'b1;
                        w_state_nxt   = S_DISPATCH;
                    end else begin
                        w_state_nxt = S_DONE;
                    end
                end
            end
            S_DONE: begin
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // Datapath, engine table, arbiter grant and registered outputs
    // ------------------------------------------------------------------------
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            r_busy       <= 1'b0;
            r_frame_done <= 1'b0;
            r_job_x      <= '0;
            r_job_y      <= '0;
            r_eng_start  <= '0;
            r_wr_en      <= 1'b0;
            r_wr_addr    <= '0;
            r_wr_data    <= '0;
            r_eng_busy   <= '0;
            r_pend       <= '0;
            r_rr_ptr     <= '0;
            r_pix        <= '0;
            r_x          <= '0;
            r_y          <= '0;
            r_restart    <= 1'b0;
            for (int i = 0; i < NUM_ENG; i++) begin
                r_tag[i] <= '0;
                r_res[i] <= '0;
            end
        end else begin
            // Status follows the state being entered so it lines up with it.
            r_busy       <= (w_state_nxt == S_DISPATCH) || (w_state_nxt == S_DRAIN);
            r_frame_done <= (w_state_nxt == S_DONE);

            r_eng_start <= w_do_dispatch ? w_disp_oh : '0;
            if (w_do_dispatch) begin
                r_job_x <= r_x;
                r_job_y <= r_y;
            end

            for (int i = 0; i < NUM_ENG; i++) begin
                if (w_do_dispatch && w_disp_oh[i]) begin
                    r_tag[i] <= r_pix;
                end
                if (w_done_acc[i]) begin
                    r_res[i] <= bus.eng_iter[i*ITER_WIDTH +: ITER_WIDTH];
                end
            end

            // A granted engine is released on the same edge its write is
            // registered, so it can take a new job from the next cycle.
            r_eng_busy <= (r_eng_busy & ~w_grant_oh) | (w_do_dispatch ? w_disp_oh : '0);
            r_pend     <= (r_pend & ~w_grant_oh) | w_done_acc;

            r_wr_en <= w_grant_vld;
            if (w_grant_vld) begin
                r_wr_addr <= r_tag[w_grant_idx];
                r_wr_data <= r_res[w_grant_idx];
                r_rr_ptr  <= w_rr_nxt;
            end

            if (w_clr_cnt) begin
                r_pix <= '0;
                r_x   <= '0;
                r_y   <= '0;
            end else if (w_do_dispatch) begin
                r_pix <= r_pix + ADDR_WIDTH'(1);
                if (r_x == c_LAST_X) begin
                    r_x <= '0;
                    r_y <= r_y + 16'd1;
                end else begin
                    r_x <= r_x + 16'd1;
                end
            end

            if (w_clr_restart) begin
                r_restart <= 1'b0;
            end else if (w_set_restart) begin
                r_restart <= 1'b1;
            end
        end
    end

    // Results from a free engine or one whose result is still waiting are
    // dropped by w_done_acc; flag them in simulation.
    always @(posedge CLK) begin
        if (RESET) begin
            assert ((bus.eng_done & ~w_done_ok) == '0)
                else $error("mandel_scheduler: eng_done from a free or already-pending engine");
        end
    end

    assign bus.busy       = r_busy;
    assign bus.frame_done = r_frame_done;
    assign bus.job_x      = r_job_x;
    assign bus.job_y      = r_job_y;
    assign bus.eng_start  = r_eng_start;
    assign bus.wr_en      = r_wr_en;
    assign bus.wr_addr    = r_wr_addr;
    assign bus.wr_data    = r_wr_data;

endmodule
`default_nettype wire

// File: tb/tb_mandel_scheduler.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_mandel_scheduler
// Description : Directed self-checking bench for mandel_scheduler on a 4x2
//               frame with two behavioural engines of programmable latency.
//               Each engine returns iter = (y*H_RES + x)[4:0], so every write
//               must carry wr_data == wr_addr.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mandel_scheduler;
    localparam int c_H  = 4;
    localparam int c_V  = 2;
    localparam int c_NE = 2;
    localparam int c_AW = 3;
    localparam int c_IW = 5;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    mandel_scheduler_if #(.NUM_ENG(c_NE), .ADDR_WIDTH(c_AW), .ITER_WIDTH(c_IW)) bus ();

    mandel_scheduler #(
        .H_RES(c_H), .V_RES(c_V), .NUM_ENG(c_NE), .ADDR_WIDTH(c_AW), .ITER_WIDTH(c_IW)
    ) dut (
        .CLK   (clk),
        .RESET (rst_n),
        .bus   (bus)
    );

    int n_cmp = 0;
    int n_bad = 0;

    // ---------------- behavioural engines ----------------
    int lat [c_NE];
    int cnt [c_NE];

    always @(negedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.eng_done = '0;
            bus.eng_iter = '0;
            for (int i = 0; i < c_NE; i++) cnt[i] = 0;
        end else begin
            for (int i = 0; i < c_NE; i++) begin
                bus.eng_done[i] = 1'b0;
                if (cnt[i] > 0) begin
                    cnt[i] = cnt[i] - 1;
                    if (cnt[i] == 0) bus.eng_done[i] = 1'b1;
                end
                if (bus.eng_start[i] === 1'b1) begin
                    cnt[i] = lat[i];
                    bus.eng_iter[i*c_IW +: c_IW] = c_IW'(int'(bus.job_y) * c_H + int'(bus.job_x));
                end
            end
        end
    end

    // ---------------- monitor ----------------
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int wa[$], wd[$], wc[$];
    int sx[$], sy[$], sc[$];
    int fd_cnt = 0, fd_cyc = 0, n_busy = 0, max_out = 0;

    always @(negedge clk) begin
        if (bus.wr_en === 1'b1) begin
            wa.push_back(int'(bus.wr_addr));
            wd.push_back(int'(bus.wr_data));
            wc.push_back(cyc);
        end
        if (bus.eng_start !== '0 && !$isunknown(bus.eng_start)) begin
            sx.push_back(int'(bus.job_x));
            sy.push_back(int'(bus.job_y));
            sc.push_back(cyc);
        end
        if (bus.frame_done === 1'b1) begin
            fd_cnt++;
            fd_cyc = cyc;
        end
        if (bus.busy === 1'b1) n_busy++;
        if (sc.size() - wa.size() > max_out) max_out = sc.size() - wa.size();
    end

    // ---------------- helpers ----------------
    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic clear_logs();
        wa.delete(); wd.delete(); wc.delete();
        sx.delete(); sy.delete(); sc.delete();
        fd_cnt = 0; fd_cyc = 0; n_busy = 0; max_out = 0;
    endtask

    task automatic pulse_start();
        bus.start = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
    endtask

    task automatic wait_frame(input int budget);
        int g;
        g = 0;
        while (fd_cnt == 0 && g < budget) begin
            @(posedge clk); #1;
            g++;
        end
        repeat (4) @(posedge clk);
        #1;
    endtask

    function automatic int addr_mask();
        int m;
        m = 0;
        foreach (wa[i]) if (wa[i] >= 0 && wa[i] < 31) m |= (1 << wa[i]);
        return m;
    endfunction

    function automatic int data_errs();
        int e;
        e = 0;
        foreach (wa[i]) if (wd[i] != wa[i]) e++;
        return e;
    endfunction

    // ---------------- directed sequence ----------------
    initial begin
        int seen, guard, c3, pre, pre_m, post, post_m, last_wc;
        bus.start = 1'b0;
        lat[0] = 3;
        lat[1] = 3;
        #1 rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        // Reset state
        check("rst_busy", 64'(bus.busy), 64'd0);
        check("rst_ctl", 64'({bus.frame_done, bus.eng_start, bus.wr_en}), 64'd0);
        check("rst_data", 64'({bus.job_x, bus.job_y, bus.wr_addr, bus.wr_data}), 64'd0);
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;
        clear_logs();

        // ---- Frame 1: 3-cycle engines ----
        pulse_start();
        check("f1_busy_after_start", 64'(bus.busy), 64'd1);
        wait_frame(300);
        check("f1_n_start", 64'(sc.size()), 64'd8);
        for (int k = 0; k < 8; k++) begin
            if (k < sx.size())
                check($sformatf("f1_xy%0d", k), 64'(sx[k] * 256 + sy[k]), 64'((k % c_H) * 256 + k / c_H));
        end
        check("f1_n_wr", 64'(wa.size()), 64'd8);
        check("f1_addr_set", 64'(addr_mask()), 64'hFF);
        check("f1_data_eq_addr", 64'(data_errs()), 64'd0);
        check("f1_fd_count", 64'(fd_cnt), 64'd1);
        last_wc = (wc.size() > 0) ? wc[wc.size()-1] : -10;
        check("f1_fd_after_last_wr", 64'(fd_cyc - last_wc), 64'd1);
        check("f1_busy_idle", 64'(bus.busy), 64'd0);
        clear_logs();

        // ---- Out-of-order: engine 1 finishes 2 cycles before engine 0 ----
        lat[0] = 6;
        lat[1] = 3;
        pulse_start();
        wait_frame(300);
        check("ooo_first_addr", 64'((wa.size() > 0) ? wa[0] : -1), 64'd1);
        check("ooo_second_addr", 64'((wa.size() > 1) ? wa[1] : -1), 64'd0);
        check("ooo_data", 64'(data_errs()), 64'd0);
        check("ooo_addr_set", 64'(addr_mask()), 64'hFF);
        check("ooo_n_wr", 64'(wa.size()), 64'd8);
        check("ooo_fd_count", 64'(fd_cnt), 64'd1);
        clear_logs();

        // ---- Simultaneous results: engine 0 first, then pointer back at 0 ----
        lat[0] = 4;
        lat[1] = 3;
        pulse_start();
        wait_frame(300);
        check("sim_n_wr", 64'(wa.size()), 64'd8);
        for (int k = 0; k < 8; k++) begin
            if (k < wa.size()) check($sformatf("sim_order%0d", k), 64'(wa[k]), 64'(k));
        end
        check("sim_back_to_back", 64'((wc.size() > 1) ? wc[1] - wc[0] : -1), 64'd1);
        check("sim_data", 64'(data_errs()), 64'd0);
        clear_logs();

        // ---- Slow engines: dispatch stalls while both are busy ----
        lat[0] = 20;
        lat[1] = 20;
        pulse_start();
        wait_frame(600);
        check("slow_n_start", 64'(sc.size()), 64'd8);
        check("slow_gap0", 64'((sc.size() > 2) ? sc[2] - sc[0] : -1), 64'd23);
        check("slow_gap1", 64'((sc.size() > 3) ? sc[3] - sc[1] : -1), 64'd23);
        check("slow_max_outstanding", 64'(max_out), 64'd2);
        check("slow_n_wr", 64'(wa.size()), 64'd8);
        check("slow_addr_set", 64'(addr_mask()), 64'hFF);
        check("slow_fd_count", 64'(fd_cnt), 64'd1);
        clear_logs();

        // ---- Restart: start pulsed while the third job is dispatched ----
        lat[0] = 3;
        lat[1] = 3;
        pulse_start();
        seen = 0;
        guard = 0;
        while (seen < 3 && guard < 100) begin
            @(posedge clk); #1;
            if (bus.eng_start !== '0) seen++;
            guard++;
        end
        check("rs_third_seen", 64'(seen), 64'd3);
        pulse_start();
        check("rs_busy_drain", 64'(bus.busy), 64'd1);
        check("rs_no_dispatch", 64'(bus.eng_start), 64'd0);
        wait_frame(400);
        check("rs_n_start", 64'(sc.size()), 64'd11);
        check("rs_third_xy", 64'((sc.size() > 2) ? sx[2] * 256 + sy[2] : -1), 64'(2 * 256 + 0));
        check("rs_restart_xy", 64'((sc.size() > 3) ? sx[3] * 256 + sy[3] : -1), 64'd0);
        c3 = (sc.size() > 3) ? sc[3] : 0;
        pre = 0; pre_m = 0; post = 0; post_m = 0;
        foreach (wc[i]) begin
            if (wc[i] < c3) begin
                pre++;
                pre_m |= (1 << wa[i]);
            end else begin
                post++;
                post_m |= (1 << wa[i]);
            end
        end
        check("rs_pre_n_wr", 64'(pre), 64'd3);
        check("rs_pre_set", 64'(pre_m), 64'h07);
        check("rs_post_n_wr", 64'(post), 64'd8);
        check("rs_post_set", 64'(post_m), 64'hFF);
        check("rs_data", 64'(data_errs()), 64'd0);
        check("rs_fd_count", 64'(fd_cnt), 64'd1);
        last_wc = (wc.size() > 0) ? wc[wc.size()-1] : -10;
        check("rs_fd_after_last_wr", 64'(fd_cyc - last_wc), 64'd1);
        clear_logs();

        // ---- Asynchronous reset in the middle of dispatch ----
        pulse_start();
        seen = 0;
        guard = 0;
        while (seen < 2 && guard < 100) begin
            @(posedge clk); #1;
            if (bus.eng_start !== '0) seen++;
            guard++;
        end
        check("ar_pre_busy", 64'(bus.busy), 64'd1);
        #1 rst_n = 1'b0;
        #1;
        check("ar_ctl_zero", 64'({bus.busy, bus.frame_done, bus.eng_start, bus.wr_en}), 64'd0);
        check("ar_data_zero", 64'({bus.job_x, bus.job_y, bus.wr_addr, bus.wr_data}), 64'd0);
        repeat (2) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;
        clear_logs();
        repeat (50) @(posedge clk);
        #1;
        check("ar_idle_starts", 64'(sc.size()), 64'd0);
        check("ar_idle_writes", 64'(wa.size()), 64'd0);
        check("ar_idle_busy", 64'(n_busy), 64'd0);
        check("ar_idle_fd", 64'(fd_cnt), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, compared %0d", n_cmp);
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
